cfu_rr_arbiter: RTL and testbench

- Shares one downstream CFU (full handshaken CFU interface) among N_REQ requesters, e.g. several cores or harts.
- Requests are arbitrated round-robin into a one-entry registered output stage.
- Downstream IDs are tagged with the requester index, so responses route back without an ordering assumption.
- Per-requester credit counters bound the number of outstanding transactions.

---
 rtl/cfu_arb_pkg.sv | 18 +
 rtl/cfu_rr_pick.sv | 31 +++
 rtl/cfu_rr_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_cfu_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_arb_pkg.sv
// Shared constants, helpers and types for the CFU round-robin arbiter.
package cfu_arb_pkg;

  localparam int CNT_W     = 4;
  localparam int SEL_MAX_W = 3;
  localparam int DEF_ID_W  = 6;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widest tag layout (eight requesters, default ID width); the top builds its own sized copy.
  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel;
    logic [DEF_ID_W-1:0]  id;
  } cfu_tag_t;

endpackage

// File: rtl/cfu_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
module cfu_rr_pick
  import cfu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int SEL_W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (!o_any && i_eligible[j]) begin
        o_any      = 1'b1;
        o_idx      = SEL_W'(j);
        o_grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfu_rr_arbiter.sv
// Shares one downstream CFU among N_REQ requesters with round-robin grants and per-requester credits.
// Optional grant/stall counters are built when CFU_ARB_PERF_EN is defined.
module cfu_rr_arbiter
  import cfu_arb_pkg::*;
#(
  parameter int  N_REQ             = 2,
  parameter int  CFU_FUNCTION_ID_W = 16,
  parameter int  CFU_REQ_RESP_ID_W = 6,
  parameter int  CFU_REQ_INPUTS    = 2,
  parameter int  CFU_REQ_DATA_W    = 32,
  parameter int  CFU_RESP_DATA_W   = 32,
  parameter int  CFU_ERROR_ID_W    = 32,
  parameter int  MAX_OUTST         = 4,
  localparam int SEL_W             = sel_w(N_REQ),
  localparam int TAG_W             = SEL_W + CFU_REQ_RESP_ID_W
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              clock_en,
  input  logic [N_REQ-1:0]                                  req_valid,
  output logic [N_REQ-1:0]                                  req_ready,
  input  logic [N_REQ*CFU_FUNCTION_ID_W-1:0]                req_function_id,
  input  logic [N_REQ*CFU_REQ_RESP_ID_W-1:0]                req_id,
  input  logic [N_REQ*CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]                                  resp_valid,
  input  logic [N_REQ-1:0]                                  resp_ready,
  output logic [CFU_REQ_RESP_ID_W-1:0]                      resp_id,
  output logic [CFU_RESP_DATA_W-1:0]                        resp_data,
  output logic                                              resp_ok,
  output logic [CFU_ERROR_ID_W-1:0]                         resp_error_id,
  output logic                                              cfu_req_valid,
  input  logic                                              cfu_req_ready,
  output logic [CFU_FUNCTION_ID_W-1:0]                      cfu_req_function_id,
  output logic [TAG_W-1:0]                                  cfu_req_id,
  output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]          cfu_req_data,
  input  logic                                              cfu_resp_valid,
  output logic                                              cfu_resp_ready,
  input  logic [TAG_W-1:0]                                  cfu_resp_id,
  input  logic [CFU_RESP_DATA_W-1:0]                        cfu_resp_data,
  input  logic                                              cfu_resp_ok,
`ifdef CFU_ARB_PERF_EN
  output logic [N_REQ*32-1:0]                               perf_grants,
  output logic [N_REQ*32-1:0]                               perf_stalls,
`endif
  input  logic [CFU_ERROR_ID_W-1:0]                         cfu_resp_error_id
);

  localparam int                OPS_W   = CFU_REQ_INPUTS * CFU_REQ_DATA_W;
  localparam int                FID_W   = CFU_FUNCTION_ID_W;
  localparam int                UID_W   = CFU_REQ_RESP_ID_W;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [SEL_W-1:0]  LAST    = SEL_W'(N_REQ - 1);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [UID_W-1:0] id;
  } tag_t;

  logic             r_valid;
  logic [FID_W-1:0] r_func;
  tag_t             r_tag;
  logic [OPS_W-1:0] r_ops;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt [N_REQ];

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_onehot;
  logic [N_REQ-1:0] w_dec;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_en;
  logic             w_adv;
  logic             w_grant;
  logic [FID_W-1:0] w_win_func;
  logic [UID_W-1:0] w_win_id;
  logic [OPS_W-1:0] w_win_ops;
  tag_t             w_resp_tag;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = req_valid[i] && (r_cnt[i] < MAX_CNT);
    end
  end

  cfu_rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_grant    (w_onehot),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  // Reset is held off the handshakes so nothing is accepted into state that is being cleared.
  assign w_en      = clock_en && !reset;
  assign w_adv     = w_en && (!r_valid || cfu_req_ready);
  assign w_grant   = w_adv && w_any;
  assign req_ready = w_grant ? w_onehot : '0;

  always_comb begin
    w_win_func = '0;
    w_win_id   = '0;
    w_win_ops  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_onehot[i]) begin
        w_win_func = req_function_id[i*FID_W +: FID_W];
        w_win_id   = req_id[i*UID_W +: UID_W];
        w_win_ops  = req_data[i*OPS_W +: OPS_W];
      end
    end
  end

  // Output stage reloads whenever the slot frees up; payload registers need no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_adv) begin
      r_valid <= w_any;
      if (w_any) begin
        r_func    <= w_win_func;
        r_tag.sel <= w_idx;
        r_tag.id  <= w_win_id;
        r_ops     <= w_win_ops;
        r_ptr     <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign cfu_req_valid       = r_valid && clock_en;
  assign cfu_req_function_id = r_func;
  assign cfu_req_id          = r_tag;
  assign cfu_req_data        = r_ops;

  assign w_resp_tag    = cfu_resp_id;
  assign resp_id       = w_resp_tag.id;
  assign resp_data     = cfu_resp_data;
  assign resp_ok       = cfu_resp_ok;
  assign resp_error_id = cfu_resp_error_id;

  // An unmatched select keeps the default ready, so stray responses are drained and dropped.
  always_comb begin
    resp_valid     = '0;
    cfu_resp_ready = w_en;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_resp_tag.sel == SEL_W'(i)) begin
        resp_valid[i]  = w_en && cfu_resp_valid;
        cfu_resp_ready = w_en && resp_ready[i];
      end
    end
  end

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dec[i] = resp_valid[i] && resp_ready[i] && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else begin
        case ({req_ready[i], w_dec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

`ifdef CFU_ARB_PERF_EN
  logic [31:0] r_perf_grants [N_REQ];
  logic [31:0] r_perf_stalls [N_REQ];

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        r_perf_grants[i] <= '0;
        r_perf_stalls[i] <= '0;
      end else begin
        if (req_ready[i]) begin
          r_perf_grants[i] <= r_perf_grants[i] + 32'd1;
        end
        if (req_valid[i] && clock_en && !req_ready[i]) begin
          r_perf_stalls[i] <= r_perf_stalls[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    perf_stalls = '0;
    for (int i = 0; i < N_REQ; i++) begin
      perf_grants[i*32 +: 32] = r_perf_grants[i];
      perf_stalls[i*32 +: 32] = r_perf_stalls[i];
    end
  end
`endif

endmodule

// File: tb/tb_cfu_rr_arbiter.sv
// Directed bench for cfu_rr_arbiter with three requesters and two credits each.
module tb_cfu_rr_arbiter;

  localparam int N   = 3;
  localparam int FW  = 16;
  localparam int IW  = 6;
  localparam int OW  = 64;
  localparam int TW  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            clock_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_function_id;
  logic [N*IW-1:0] req_id;
  logic [N*OW-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_data;
  logic            resp_ok;
  logic [31:0]     resp_error_id;
  logic            cfu_req_valid;
  logic            cfu_req_ready;
  logic [FW-1:0]   cfu_req_function_id;
  logic [TW-1:0]   cfu_req_id;
  logic [OW-1:0]   cfu_req_data;
  logic            cfu_resp_valid;
  logic            cfu_resp_ready;
  logic [TW-1:0]   cfu_resp_id;
  logic [31:0]     cfu_resp_data;
  logic            cfu_resp_ok;
  logic [31:0]     cfu_resp_error_id;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  cfu_rr_arbiter #(
    .N_REQ     (N),
    .MAX_OUTST (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .clock_en            (clock_en),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_function_id     (req_function_id),
    .req_id              (req_id),
    .req_data            (req_data),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_id             (resp_id),
    .resp_data           (resp_data),
    .resp_ok             (resp_ok),
    .resp_error_id       (resp_error_id),
    .cfu_req_valid       (cfu_req_valid),
    .cfu_req_ready       (cfu_req_ready),
    .cfu_req_function_id (cfu_req_function_id),
    .cfu_req_id          (cfu_req_id),
    .cfu_req_data        (cfu_req_data),
    .cfu_resp_valid      (cfu_resp_valid),
    .cfu_resp_ready      (cfu_resp_ready),
    .cfu_resp_id         (cfu_resp_id),
    .cfu_resp_data       (cfu_resp_data),
    .cfu_resp_ok         (cfu_resp_ok),
    .cfu_resp_error_id   (cfu_resp_error_id)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rready, input logic creqReady);
    req_valid     = valid;
    resp_ready    = rready;
    cfu_req_ready = creqReady;
    #1;
  endtask

  initial begin
    logic [1:0] s;
    logic [7:0] expTag;

    reset             = 1'b1;
    clock_en          = 1'b1;
    req_valid         = '0;
    resp_ready        = '0;
    cfu_req_ready     = 1'b0;
    cfu_resp_valid    = 1'b0;
    cfu_resp_id       = '0;
    cfu_resp_data     = '0;
    cfu_resp_ok       = 1'b0;
    cfu_resp_error_id = '0;
    for (int i = 0; i < N; i++) begin
      req_function_id[i*FW +: FW] = 16'h100 + 16'(i);
      req_id[i*IW +: IW]          = 6'(10 + i);
      req_data[i*OW +: OW]        = {32'(20 + i), 32'(30 + i)};
    end
    req_id[IW-1:0]   = 6'd5;
    req_data[OW-1:0] = {32'd7, 32'd3};

    tick();
    tick();
    checkOutput("rst_cfu_req_valid", 64'(cfu_req_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;

    // Single request and its routed response
    applyStimulus(3'b001, 3'b000, 1'b1);
    checkOutput("single_grant", 64'(req_ready), 64'h1);
    tick();
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkOutput("single_valid", 64'(cfu_req_valid), 64'd1);
    checkOutput("single_tag", 64'(cfu_req_id), 64'h05);
    checkOutput("single_data", cfu_req_data, {32'd7, 32'd3});
    checkOutput("single_func", 64'(cfu_req_function_id), 64'h100);
    tick();
    checkOutput("single_drain", 64'(cfu_req_valid), 64'd0);
    cfu_resp_valid    = 1'b1;
    cfu_resp_id       = 8'h05;
    cfu_resp_data     = 32'd21;
    cfu_resp_ok       = 1'b1;
    cfu_resp_error_id = 32'h0E;
    applyStimulus(3'b000, 3'b001, 1'b1);
    checkOutput("resp_valid0", 64'(resp_valid), 64'h1);
    checkOutput("resp_id0", 64'(resp_id), 64'd5);
    checkOutput("resp_data0", 64'(resp_data), 64'd21);
    checkOutput("resp_ok0", 64'(resp_ok), 64'd1);
    checkOutput("resp_err0", 64'(resp_error_id), 64'h0E);
    checkOutput("resp_rdy0", 64'(cfu_resp_ready), 64'd1);
    tick();
    cfu_resp_valid   = 1'b0;
    req_id[IW-1:0]   = 6'd10;
    req_data[OW-1:0] = {32'd20, 32'd30};

    // Reset blocks handshakes and returns the pointer to requester 0
    reset = 1'b1;
    applyStimulus(3'b111, 3'b000, 1'b1);
    checkOutput("rst_hold_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    for (int k = 0; k < 6; k++) begin
      checkOutput("fair_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      s      = 2'(k % 3);
      expTag = {s, 6'(10 + k % 3)};
      checkOutput("fair_tag", 64'(cfu_req_id), 64'(expTag));
    end

    // Two credits each are now used up
    checkOutput("credit_block", 64'(req_ready), 64'd0);
    tick();
    checkOutput("credit_drain", 64'(cfu_req_valid), 64'd0);
    tick();
    tick();
    checkOutput("credit_block_hold", 64'(req_ready), 64'd0);
    cfu_resp_valid = 1'b1;
    cfu_resp_id    = 8'h0A;
    applyStimulus(3'b111, 3'b111, 1'b1);
    checkOutput("credit_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("credit_same_cycle", 64'(req_ready), 64'd0);
    tick();
    cfu_resp_valid = 1'b0;
    #1;
    checkOutput("credit_regrant", 64'(req_ready), 64'h1);
    tick();
    checkOutput("credit_one_more", 64'(req_ready), 64'd0);

    // Response stall for requester 1
    cfu_resp_valid = 1'b1;
    cfu_resp_id    = 8'h4B;
    applyStimulus(3'b111, 3'b000, 1'b1);
    checkOutput("stall_cfu_ready", 64'(cfu_resp_ready), 64'd0);
    checkOutput("stall_valid", 64'(resp_valid), 64'h2);
    tick();
    checkOutput("stall_cnt_kept", 64'(req_ready), 64'd0);
    applyStimulus(3'b111, 3'b010, 1'b1);
    checkOutput("stall_release", 64'(cfu_resp_ready), 64'd1);
    tick();
    cfu_resp_valid = 1'b0;

    // Out-of-range select is drained without touching any credit
    cfu_resp_valid = 1'b1;
    cfu_resp_id    = 8'hC0;
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkOutput("oor_ready", 64'(cfu_resp_ready), 64'd1);
    checkOutput("oor_valid", 64'(resp_valid), 64'd0);
    tick();
    cfu_resp_valid = 1'b0;
    applyStimulus(3'b111, 3'b000, 1'b1);
    checkOutput("oor_cnt_kept", 64'(req_ready), 64'h2);

    // Reset with credits outstanding
    reset = 1'b1;
    #1;
    checkOutput("rst2_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(3'b111, 3'b000, 1'b0);
    checkOutput("rst2_resume", 64'(req_ready), 64'h1);
    tick();

    // Downstream backpressure
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_no_ready", 64'(req_ready), 64'd0);
      checkOutput("bp_valid", 64'(cfu_req_valid), 64'd1);
      checkOutput("bp_tag", 64'(cfu_req_id), 64'h0A);
      checkOutput("bp_data", cfu_req_data, {32'd20, 32'd30});
      tick();
    end
    applyStimulus(3'b111, 3'b000, 1'b1);
    checkOutput("bp_release_grant", 64'(req_ready), 64'h2);
    tick();
    checkOutput("bp_next_tag", 64'(cfu_req_id), 64'h4B);

    // Clock enable low freezes everything, including a pending response for requester 0
    clock_en       = 1'b0;
    cfu_resp_valid = 1'b1;
    cfu_resp_id    = 8'h0A;
    applyStimulus(3'b111, 3'b111, 1'b1);
    checkOutput("ce_req_ready", 64'(req_ready), 64'd0);
    checkOutput("ce_cfu_valid", 64'(cfu_req_valid), 64'd0);
    checkOutput("ce_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("ce_resp_ready", 64'(cfu_resp_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("ce_hold_ready", 64'(req_ready), 64'd0);
    end
    clock_en       = 1'b1;
    cfu_resp_valid = 1'b0;
    #1;
    checkOutput("ce_stage_kept", 64'(cfu_req_valid), 64'd1);
    checkOutput("ce_tag_kept", 64'(cfu_req_id), 64'h4B);
    checkOutput("ce_ptr_kept", 64'(req_ready), 64'h4);
    tick();
    checkOutput("ce_tag2", 64'(cfu_req_id), 64'h8C);
    checkOutput("ce_grant0", 64'(req_ready), 64'h1);
    tick();
    checkOutput("ce_grant1", 64'(req_ready), 64'h2);
    tick();
    checkOutput("ce_grant2", 64'(req_ready), 64'h4);
    tick();
    checkOutput("ce_cnt_frozen", 64'(req_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
